// File: rtl/algo_nrnw_ref_chk.sv
// -----------------------------------------------------------------------------
// algo_nrnw_ref_chk
//
// Data-integrity monitor for NR-read / NW-write multiport memory algorithms.
// It sits beside a memory implementation and watches the same request ports.
//
// How it works:
// - A shadow memory tracks every bit-masked write.
// - Each read captures the expected data read-first, together with a
//   "checkable" flag. The flag is set when the address was written since reset.
// - Both travel down a LAT-deep pipeline and are compared against the
//   implementation's rd_vld / rd_dout at exit.
// - Failures are counted, and the first failing cycle is captured.
//
// Ports:
//   clk          clock
//   rst          synchronous reset, active-low
//   read         per-port read request                 [NUMRDPRT]
//   rd_adr       read addresses, port p at [p*BITADDR +: BITADDR]
//   rd_vld       implementation read-valid             [NUMRDPRT]
//   rd_dout      implementation read data, port p at [p*WIDTH +: WIDTH]
//   write        per-port write request                [NUMWRPRT]
//   wr_adr       write addresses
//   din          write data
//   bw           bit-write enables
//   err          sticky: any failure (or write conflict) since reset
//   err_vld      one-cycle pulse per port, rd_vld disagrees with issued read
//   err_data     one-cycle pulse per port, data mismatch on a checkable read
//   wr_conflict  one-cycle pulse, same-address writes with overlapping bw
//   err_port     ports failing in the first failing cycle
//   err_adr      address of the lowest failing port in that cycle
//   err_cnt      saturating count of failing port-events
//   chk_cnt      saturating count of data comparisons performed
// -----------------------------------------------------------------------------
module algo_nrnw_ref_chk #(
  parameter int NUMRDPRT = 3,
  parameter int NUMWRPRT = 3,
  parameter int WIDTH    = 15,
  parameter int NUMADDR  = 256,
  parameter int BITADDR  = 8,
  parameter int DELAY    = 2,
  parameter int FLOPOUT  = 0,
  parameter int BITCNT   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUMRDPRT-1:0]          read,
  input  logic [NUMRDPRT*BITADDR-1:0]  rd_adr,
  input  logic [NUMRDPRT-1:0]          rd_vld,
  input  logic [NUMRDPRT*WIDTH-1:0]    rd_dout,
  input  logic [NUMWRPRT-1:0]          write,
  input  logic [NUMWRPRT*BITADDR-1:0]  wr_adr,
  input  logic [NUMWRPRT*WIDTH-1:0]    din,
  input  logic [NUMWRPRT*WIDTH-1:0]    bw,
  output logic                         err,
  output logic [NUMRDPRT-1:0]          err_vld,
  output logic [NUMRDPRT-1:0]          err_data,
  output logic                         wr_conflict,
  output logic [NUMRDPRT-1:0]          err_port,
  output logic [BITADDR-1:0]           err_adr,
  output logic [BITCNT-1:0]            err_cnt,
  output logic [BITCNT-1:0]            chk_cnt
);

  localparam int LAT = DELAY + FLOPOUT;

  // Number of set bits in a per-port vector, sized to the counter width.
  function automatic logic [BITCNT-1:0] pop_cnt(input logic [NUMRDPRT-1:0] vec);
    logic [BITCNT-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUMRDPRT; i++) begin
      cnt = cnt + {{(BITCNT-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

  // Counter addition that sticks at all-ones instead of wrapping.
  function automatic logic [BITCNT-1:0] sat_add(input logic [BITCNT-1:0] a,
                                                input logic [BITCNT-1:0] b);
    logic [BITCNT:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum[BITCNT]) begin
      return '1;
    end else begin
      return sum[BITCNT-1:0];
    end
  endfunction

  // Shadow state. mem_r is never reset; wrt_r gates whether its content is trusted.
  logic [WIDTH-1:0]            mem_r [NUMADDR];
  logic [NUMADDR-1:0]          wrt_r;

  // Read-side lookups, taken before this cycle's writes land (read-first).
  logic [NUMRDPRT*WIDTH-1:0]   rd_exp_s;
  logic [NUMRDPRT-1:0]         rd_chk_s;

  // Merged write value per port, and conflict detection.
  logic [NUMWRPRT*WIDTH-1:0]   wr_val_s;
  logic                        conflict_s;

  // Read pipeline, one entry per stage; stage LAT-1 is the compare point.
  logic [NUMRDPRT-1:0]         pl_rd_r  [LAT];
  logic [NUMRDPRT*BITADDR-1:0] pl_adr_r [LAT];
  logic [NUMRDPRT*WIDTH-1:0]   pl_exp_r [LAT];
  logic [NUMRDPRT-1:0]         pl_chk_r [LAT];
  // Stage-occupied flags: a stage is live only when filled out of reset.
  // This keeps the first LAT cycles after release free of any checks.
  logic [LAT-1:0]              pl_live_r;

  // Compare results at pipeline exit.
  logic [NUMRDPRT-1:0]         fail_vld_s;
  logic [NUMRDPRT-1:0]         fail_data_s;
  logic [NUMRDPRT-1:0]         fail_any_s;
  logic [NUMRDPRT-1:0]         check_s;
  logic [BITADDR-1:0]          fail_adr_s;

  // Expected data and checkable flag per read port, from pre-write state.
  always_comb begin
    rd_exp_s = '0;
    rd_chk_s = '0;
    for (int p = 0; p < NUMRDPRT; p++) begin
      rd_exp_s[p*WIDTH +: WIDTH] = mem_r[rd_adr[p*BITADDR +: BITADDR]];
      rd_chk_s[p]                = wrt_r[rd_adr[p*BITADDR +: BITADDR]];
    end
  end

  // Per write port p: fold in every port q <= p aimed at the same address, in
  // ascending order. The highest port touching an address therefore holds the
  // full merge, and because it is also the last non-blocking store to that
  // address, it is the one that lands.
  always_comb begin
    wr_val_s = '0;
    for (int p = 0; p < NUMWRPRT; p++) begin
      wr_val_s[p*WIDTH +: WIDTH] = mem_r[wr_adr[p*BITADDR +: BITADDR]];
      for (int q = 0; q <= p; q++) begin
        if (write[q] && (wr_adr[q*BITADDR +: BITADDR] == wr_adr[p*BITADDR +: BITADDR])) begin
          wr_val_s[p*WIDTH +: WIDTH] = (wr_val_s[p*WIDTH +: WIDTH] & ~bw[q*WIDTH +: WIDTH]) |
                                       (din[q*WIDTH +: WIDTH] & bw[q*WIDTH +: WIDTH]);
        end else begin
          wr_val_s[p*WIDTH +: WIDTH] = wr_val_s[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Two write ports hitting one address conflict only when their masks overlap.
  always_comb begin
    conflict_s = 1'b0;
    for (int p = 0; p < NUMWRPRT; p++) begin
      for (int q = p + 1; q < NUMWRPRT; q++) begin
        if (write[p] && write[q] &&
            (wr_adr[p*BITADDR +: BITADDR] == wr_adr[q*BITADDR +: BITADDR]) &&
            (|(bw[p*WIDTH +: WIDTH] & bw[q*WIDTH +: WIDTH]))) begin
          conflict_s = 1'b1;
        end else begin
          conflict_s = conflict_s;
        end
      end
    end
  end

  // Shadow memory store; ascending port order lets the full merge win.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < NUMWRPRT; p++) begin
        if (write[p]) begin
          mem_r[wr_adr[p*BITADDR +: BITADDR]] <= wr_val_s[p*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Written-since-reset flags. Any write sets them, even with an all-zero mask.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wrt_r <= '0;
    end else begin
      for (int p = 0; p < NUMWRPRT; p++) begin
        if (write[p]) begin
          wrt_r[wr_adr[p*BITADDR +: BITADDR]] <= 1'b1;
        end
      end
    end
  end

  // Latency pipeline carrying {read, adr, exp, checkable} for every read port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        pl_rd_r[i]  <= '0;
        pl_adr_r[i] <= '0;
        pl_exp_r[i] <= '0;
        pl_chk_r[i] <= '0;
      end
      pl_live_r <= '0;
    end else begin
      pl_rd_r[0]   <= read;
      pl_adr_r[0]  <= rd_adr;
      pl_exp_r[0]  <= rd_exp_s;
      pl_chk_r[0]  <= rd_chk_s;
      pl_live_r[0] <= 1'b1;
      for (int i = 1; i < LAT; i++) begin
        pl_rd_r[i]   <= pl_rd_r[i-1];
        pl_adr_r[i]  <= pl_adr_r[i-1];
        pl_exp_r[i]  <= pl_exp_r[i-1];
        pl_chk_r[i]  <= pl_chk_r[i-1];
        pl_live_r[i] <= pl_live_r[i-1];
      end
    end
  end

  // Exit compare: valid mismatch always; data only for read-and-checkable.
  always_comb begin
    fail_vld_s  = '0;
    fail_data_s = '0;
    check_s     = '0;
    if (pl_live_r[LAT-1]) begin
      for (int p = 0; p < NUMRDPRT; p++) begin
        fail_vld_s[p]  = (rd_vld[p] != pl_rd_r[LAT-1][p]);
        check_s[p]     = pl_rd_r[LAT-1][p] & pl_chk_r[LAT-1][p];
        fail_data_s[p] = check_s[p] &
                         (rd_dout[p*WIDTH +: WIDTH] != pl_exp_r[LAT-1][p*WIDTH +: WIDTH]);
      end
    end else begin
      fail_vld_s  = '0;
      fail_data_s = '0;
      check_s     = '0;
    end
    fail_any_s = fail_vld_s | fail_data_s;
  end

  // Address of the lowest failing port. A descending scan leaves the lowest last.
  always_comb begin
    fail_adr_s = '0;
    for (int p = NUMRDPRT - 1; p >= 0; p--) begin
      if (fail_any_s[p]) begin
        fail_adr_s = pl_adr_r[LAT-1][p*BITADDR +: BITADDR];
      end else begin
        fail_adr_s = fail_adr_s;
      end
    end
  end

  // Registered outputs: pulses, sticky error, first-failure capture, counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err         <= 1'b0;
      err_vld     <= '0;
      err_data    <= '0;
      wr_conflict <= 1'b0;
      err_port    <= '0;
      err_adr     <= '0;
      err_cnt     <= '0;
      chk_cnt     <= '0;
    end else begin
      err_vld     <= fail_vld_s;
      err_data    <= fail_data_s;
      wr_conflict <= conflict_s;
      err_cnt     <= sat_add(err_cnt, pop_cnt(fail_any_s));
      chk_cnt     <= sat_add(chk_cnt, pop_cnt(check_s));
      // Capture is armed only until the first failure of any kind. A write
      // conflict also sets err, which freezes the capture without loading it.
      if (!err && (|fail_any_s)) begin
        err_port <= fail_any_s;
        err_adr  <= fail_adr_s;
      end
      err <= err | conflict_s | (|fail_any_s);
    end
  end

endmodule
